// File: rtl/camera_pkg.sv
// Shared camera definitions: frame geometry, RAM/pixel widths and the
// frame reader state encoding. Used by the frame reader and the capture writer.
package camera_pkg;

    localparam int FRAME_W      = 96;
    localparam int FRAME_H      = 96;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int ADDR_W       = 15;
    localparam int PIX_W        = 8;

    // Frame reader states:
    //   IDLE  - waiting for a start request
    //   FETCH - RAM addresses still to issue
    //   DRAIN - every address issued, buffered/in-flight pixels still pending
    //   DONE  - single cycle that pulses the done strobe
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } reader_state_t;

    // Pixels that will sit in the 2-entry buffer at the end of this cycle if
    // no new read is issued: what is stored, plus the RAM word landing now,
    // minus the pixel the consumer takes now.
    function automatic logic [2:0] occupancy_after(
        input logic [1:0] count,
        input logic       in_flight,
        input logic       pop
    );
        return {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel buffer between the RAM read port and the pixel consumer.
// Push and pop may happen in the same cycle, also when the buffer is full.
// The head entry is presented directly from its register, so it stays stable
// for as long as it is not popped.
module pixel_skid_fifo #(
    parameter int WIDTH = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    localparam int DEPTH = 2;

    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] entry_data [DEPTH];

    // A pop of an empty buffer is ignored; a push into a full buffer is only
    // accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'(DEPTH)) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Storage slot gi, written when the write pointer selects it
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    entry_reg <= '0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_data = entry_data[rd_ptr_reg];
    assign full      = (count_reg == 2'(DEPTH));
    assign empty     = (count_reg == 2'd0);
    assign count     = count_reg;

endmodule

// File: rtl/frame_reader.sv
// Frame reader: on a start request, streams one frame out of the frame RAM
// as a valid/ready pixel stream tagged with start-of-frame and end-of-frame.
// The RAM answers one cycle after a read strobe; returned words land in a
// 2-entry buffer, and reads are throttled so that buffered plus in-flight
// pixels never exceed the buffer, which keeps one pixel per cycle with the
// consumer always ready and loses nothing when it stalls.
module frame_reader #(
    parameter int FRAME_PIXELS = camera_pkg::FRAME_PIXELS,
    parameter int ADDR_W       = camera_pkg::ADDR_W,
    parameter int PIX_W        = camera_pkg::PIX_W
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    output logic [ADDR_W-1:0] o_RAM_Adress,
    output logic              o_RAM_Rd_En,
    input  logic [PIX_W-1:0]  i_RAM_Data,
    output logic [PIX_W-1:0]  o_Pixel,
    output logic              o_Pixel_Valid,
    input  logic              i_Pixel_Ready,
    output logic              o_SOF,
    output logic              o_EOF,
    output logic              o_Busy,
    output logic              o_Done
);

    import camera_pkg::reader_state_t;
    import camera_pkg::ST_IDLE;
    import camera_pkg::ST_FETCH;
    import camera_pkg::ST_DRAIN;
    import camera_pkg::ST_DONE;
    import camera_pkg::occupancy_after;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    // Buffer word layout: {eof, sof, pixel}
    localparam int BUF_W   = PIX_W + 2;
    localparam int SOF_BIT = PIX_W;
    localparam int EOF_BIT = PIX_W + 1;

    reader_state_t     state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              busy_reg;
    logic              done_reg;

    // Tags of the read issued last cycle, travelling with its returning data
    logic              in_flight_reg;
    logic              sof_flight_reg;
    logic              eof_flight_reg;

    logic [BUF_W-1:0]  push_word;
    logic [BUF_W-1:0]  head_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;

    logic              pixel_pop;
    logic              rd_en;
    logic              last_issue;
    logic              eof_pop;

    // A transfer happens whenever the head is valid and the consumer is ready
    assign pixel_pop = !fifo_empty && i_Pixel_Ready;

    // Issue a read only while addresses remain and the word it returns next
    // cycle is guaranteed a free slot even if the consumer stalls from now on.
    // The same-cycle pop is credited so a steady stream needs no bubbles.
    assign rd_en = (state_reg == ST_FETCH)
                && (!fifo_full || pixel_pop)
                && (occupancy_after(fifo_count, in_flight_reg, pixel_pop) < 3'd2);

    assign last_issue = rd_en && (addr_reg == LAST_ADDR);
    assign eof_pop    = pixel_pop && head_word[EOF_BIT];

    // Frame sequencing: state, read address and the busy/done strobes
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_Start) begin
                        state_reg <= ST_FETCH;
                        addr_reg  <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (rd_en) begin
                        if (last_issue) begin
                            // Every address issued; park the counter at 0
                            state_reg <= ST_DRAIN;
                            addr_reg  <= '0;
                        end else begin
                            addr_reg <= addr_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (eof_pop) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Start requests seen here are deliberately dropped
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Track the outstanding RAM read and its frame-boundary tags
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            in_flight_reg  <= 1'b0;
            sof_flight_reg <= 1'b0;
            eof_flight_reg <= 1'b0;
        end else begin
            in_flight_reg  <= rd_en;
            sof_flight_reg <= rd_en && (addr_reg == '0);
            eof_flight_reg <= last_issue;
        end
    end

    assign push_word = {eof_flight_reg, sof_flight_reg, i_RAM_Data};

    pixel_skid_fifo #(
        .WIDTH (BUF_W)
    ) u_pixel_buf (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .push      (in_flight_reg),
        .push_data (push_word),
        .pop       (pixel_pop),
        .head_data (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign o_RAM_Adress  = addr_reg;
    assign o_RAM_Rd_En   = rd_en;
    assign o_Pixel       = head_word[PIX_W-1:0];
    assign o_Pixel_Valid = !fifo_empty;
    // Tags are only meaningful alongside a valid pixel
    assign o_SOF         = !fifo_empty && head_word[SOF_BIT];
    assign o_EOF         = !fifo_empty && head_word[EOF_BIT];
    assign o_Busy        = busy_reg;
    assign o_Done        = done_reg;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: full 96x96 frame timing, random and long
// consumer stalls, ignored start requests, asynchronous mid-frame reset, and
// a single-pixel frame on a second instance.
module tb_frame_reader;

    localparam int NPIX = 9216;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance (default 9216-pixel frame)
    logic        rst;
    logic        start;
    logic        ready;
    logic [14:0] addr;
    logic        rd_en;
    logic [7:0]  ram_data;
    logic [7:0]  pixel;
    logic        valid, sof, eof, busy, done;

    // Single-pixel instance
    logic        start1;
    logic        ready1;
    logic [14:0] addr1;
    logic        rd_en1;
    logic [7:0]  ram_data1;
    logic [7:0]  pixel1;
    logic        valid1, sof1, eof1, busy1, done1;

    frame_reader dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Start       (start),
        .o_RAM_Adress  (addr),
        .o_RAM_Rd_En   (rd_en),
        .i_RAM_Data    (ram_data),
        .o_Pixel       (pixel),
        .o_Pixel_Valid (valid),
        .i_Pixel_Ready (ready),
        .o_SOF         (sof),
        .o_EOF         (eof),
        .o_Busy        (busy),
        .o_Done        (done)
    );

    frame_reader #(.FRAME_PIXELS(1)) dut1 (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Start       (start1),
        .o_RAM_Adress  (addr1),
        .o_RAM_Rd_En   (rd_en1),
        .i_RAM_Data    (ram_data1),
        .o_Pixel       (pixel1),
        .o_Pixel_Valid (valid1),
        .i_Pixel_Ready (ready1),
        .o_SOF         (sof1),
        .o_EOF         (eof1),
        .o_Busy        (busy1),
        .o_Done        (done1)
    );

    // RAM models: data = address[7:0], one cycle after the read strobe
    always @(posedge clk) if (rd_en)  ram_data  <= addr[7:0];
    always @(posedge clk) if (rd_en1) ram_data1 <= addr1[7:0];

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget && dcyc < 0; i++) begin
            step();
            if (done) dcyc = cyc;
        end
    endtask

    // ------------------------------------------------------------- ready driver
    // 0: always ready, 1: random 50%, 2: left to the main sequence
    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      ready = 1'b1;
            else if (rdy_mode == 1) ready = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------ stream monitor
    int clr_seq  = 0;
    int clr_seen = 0;
    int xfer_cnt, rd_cnt, seq_err, stall_err, tag_err, addr_err, gap_err;
    int done_cnt, max_addr, first_cyc;
    logic [7:0] last_pix;
    logic       in_frame;
    logic       prev_stall;
    logic [9:0] prev_out;

    always @(negedge clk) begin
        if (clr_seq != clr_seen) begin
            clr_seen   = clr_seq;
            xfer_cnt   = 0;  rd_cnt   = 0;  seq_err   = 0;
            stall_err  = 0;  tag_err  = 0;  addr_err  = 0;
            gap_err    = 0;  done_cnt = 0;  max_addr  = 0;
            first_cyc  = -1; last_pix = 8'h00;
            in_frame   = 1'b0;
            prev_stall = 1'b0;
            prev_out   = '0;
        end
        if ((sof || eof) && !valid) tag_err++;
        if (prev_stall && (!valid || {pixel, sof, eof} != prev_out)) stall_err++;
        if (in_frame && !valid) gap_err++;
        if (rd_en) begin
            if (addr != 15'(rd_cnt)) addr_err++;
            if (int'(addr) > max_addr) max_addr = int'(addr);
            rd_cnt++;
        end
        if (done) done_cnt++;
        if (valid && ready) begin
            if (pixel != 8'(xfer_cnt) || sof != (xfer_cnt == 0) || eof != (xfer_cnt == NPIX - 1))
                seq_err++;
            if (xfer_cnt == 0) first_cyc = cyc;
            if (eof) begin
                last_pix = pixel;
                in_frame = 1'b0;
            end else begin
                in_frame = 1'b1;
            end
            xfer_cnt++;
        end
        prev_stall = valid && !ready;
        prev_out   = {pixel, sof, eof};
    end

    task automatic clr();
        clr_seq++;
    endtask

    // Hang guard: the normal run needs about 70k cycles
    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end before 99000", cyc);
        $fatal(1);
    end

    // ------------------------------------------------------------ main sequence
    int dcyc;
    int s;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        ready  = 1'b1;
        ready1 = 1'b1;

        step();
        check("reset_outputs", {addr, rd_en, pixel, valid, sof, eof, busy, done}, 32'd0);
        while (cyc < 3) step();
        rst = 1'b0;
        clr();

        // T1: start in cycle 10 with the consumer always ready
        while (cyc < 10) step();
        check("t1_idle_outputs", {rd_en, valid, busy, done}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_rd_en_n1", rd_en, 1);
        check("t1_addr_n1", addr, 0);
        check("t1_busy_n1", busy, 1);
        step();
        check("t1_valid_n2", valid, 0);
        step();
        check("t1_sof_pixel_n3", {valid, sof, eof, pixel}, {3'b110, 8'h00});
        wait_done(9300, dcyc);
        check("t1_done_cycle", dcyc, 9229);
        step();
        step();
        $display("frame t1: %0d pixels, done at cycle %0d", xfer_cnt, dcyc);
        check("t1_transfers", xfer_cnt, NPIX);
        check("t1_first_xfer_cycle", first_cyc, 13);
        check("t1_sequence_errors", seq_err, 0);
        check("t1_gaps", gap_err, 0);
        check("t1_tag_errors", tag_err, 0);
        check("t1_addr_errors", addr_err, 0);
        check("t1_max_addr", max_addr, NPIX - 1);
        check("t1_last_pixel", last_pix, 8'hFF);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_busy_after", busy, 0);

        // P1: single-pixel frame, done four cycles after start
        step();
        s = cyc;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("p1_rd_en", {rd_en1, addr1}, {1'b1, 15'd0});
        step();
        check("p1_valid_early", valid1, 0);
        step();
        check("p1_pixel_sof_eof", {valid1, sof1, eof1, pixel1}, {3'b111, 8'h00});
        step();
        check("p1_done", {done1, valid1}, 2'b10);
        check("p1_done_cycle", cyc - s, 4);
        $display("frame p1: 1 pixel, done at cycle %0d", cyc);

        // T2: random consumer readiness
        clr();
        rdy_mode = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(25000, dcyc);
        rdy_mode = 0;
        repeat (5) step();
        $display("frame t2: %0d pixels, done at cycle %0d", xfer_cnt, dcyc);
        check("t2_done_seen", dcyc >= 0, 1);
        check("t2_transfers", xfer_cnt, NPIX);
        check("t2_reads", rd_cnt, NPIX);
        check("t2_sequence_errors", seq_err, 0);
        check("t2_stall_errors", stall_err, 0);
        check("t2_tag_errors", tag_err, 0);
        check("t2_addr_errors", addr_err, 0);
        check("t2_done_pulses", done_cnt, 1);

        // T3: consumer holds off for 20 cycles on the SOF pixel
        clr();
        rdy_mode = 2;
        ready = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10 && !valid; i++) step();
        check("t3_sof_first", {valid, sof, eof, pixel}, {3'b110, 8'h00});
        repeat (20) step();
        check("t3_reads_le_2", rd_cnt <= 2, 1);
        check("t3_sof_held", {valid, sof, eof, pixel}, {3'b110, 8'h00});
        ready = 1'b1;
        rdy_mode = 0;
        wait_done(9300, dcyc);
        step();
        step();
        $display("frame t3: %0d pixels, done at cycle %0d", xfer_cnt, dcyc);
        check("t3_done_seen", dcyc >= 0, 1);
        check("t3_transfers", xfer_cnt, NPIX);
        check("t3_sequence_errors", seq_err, 0);
        check("t3_stall_errors", stall_err, 0);
        check("t3_gaps", gap_err, 0);

        // T4: start re-pulsed mid-frame and in the DONE cycle, then back-to-back frame
        clr();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (100) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(9300, dcyc);
        $display("frame t4a: %0d pixels, done at cycle %0d", xfer_cnt, dcyc);
        check("t4_done_seen", dcyc >= 0, 1);
        check("t4_transfers", xfer_cnt, NPIX);
        check("t4_sequence_errors", seq_err, 0);
        check("t4_addr_errors", addr_err, 0);
        clr();
        start = 1'b1;
        step();
        check("t4_done_start_ignored", {rd_en, busy}, 2'b00);
        step();
        start = 1'b0;
        check("t4_second_frame_addr0", {rd_en, addr}, {1'b1, 15'd0});
        wait_done(9300, dcyc);
        step();
        step();
        $display("frame t4b: %0d pixels, done at cycle %0d", xfer_cnt, dcyc);
        check("t4b_transfers", xfer_cnt, NPIX);
        check("t4b_sequence_errors", seq_err, 0);
        check("t4b_addr_errors", addr_err, 0);

        // T5: asynchronous reset between edges around pixel 5000
        clr();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6000 && xfer_cnt < 5000; i++) step();
        check("t5_reached_5000", xfer_cnt >= 5000, 1);
        #1;
        rst = 1'b1;
        #1;
        check("t5_async_reset", {addr, rd_en, pixel, valid, sof, eof, busy, done}, 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_stale", {valid, rd_en, busy}, 3'b000);
        end
        clr();
        start = 1'b1;
        step();
        start = 1'b0;
        check("t5_restart_addr0", {rd_en, addr}, {1'b1, 15'd0});
        wait_done(9300, dcyc);
        step();
        step();
        $display("frame t5: %0d pixels, done at cycle %0d", xfer_cnt, dcyc);
        check("t5_transfers", xfer_cnt, NPIX);
        check("t5_sequence_errors", seq_err, 0);
        check("t5_gaps", gap_err, 0);
        check("t5_last_pixel", last_pix, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
